// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencing arbiter.
package counter_seq_pkg;

  localparam int unsigned W_DEFAULT    = 4;
  localparam int unsigned WDOG_DEFAULT = 2**W_DEFAULT + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/counter_seq_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int unsigned IW = $clog2(NREQ);

  logic        found;
  int unsigned idx;

  // Scan upward from ptr and stop at the first active request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/counter_seq_arbiter.sv
// Shares one loadable counter between NREQ requesters: grants round-robin,
// loads the start value, counts to the end value, freezes and reports.
module counter_seq_arbiter
  import counter_seq_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = W_DEFAULT,
  parameter int unsigned WDOG = 2**W + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_start,
  input  logic [NREQ*W-1:0]       req_end,
  output logic [NREQ-1:0]         req_ready,
  output logic                    cnt_en,
  output logic [W-1:0]            cnt_in,
  input  logic [W-1:0]            cnt_out,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic                    timeout
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned RW = $clog2(WDOG + 1);

  state_t          state;
  logic [W-1:0]    start_q;
  logic [W-1:0]    end_q;
  logic [IW-1:0]   id_q;
  logic [W-1:0]    park_val;
  logic [IW-1:0]   rr_ptr;
  logic [RW-1:0]   run_cnt;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            any_req;
  logic [W-1:0]    sel_start;
  logic [W-1:0]    sel_end;
  logic            match;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign any_req = |req_valid;
  assign match   = (cnt_out == end_q);
  assign busy    = (state != IDLE);

  // Grant is only visible in IDLE and never while reset is held.
  assign req_ready = (state == IDLE && reset) ? gnt : '0;

  // Pick out the granted requester's start/end fields.
  always_comb begin
    sel_start = '0;
    sel_end   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_start |= req_start[i*W +: W];
        sel_end   |= req_end[i*W +: W];
      end
    end
  end

  // Counter control: park in IDLE, load start in LOAD, freeze on end in RUN.
  always_comb begin
    cnt_en = 1'b1;
    cnt_in = park_val;
    case (state)
      LOAD: begin
        cnt_en = 1'b1;
        cnt_in = start_q;
      end
      RUN: begin
        cnt_en = match;
        cnt_in = end_q;
      end
      default: begin
        cnt_en = 1'b1;
        cnt_in = park_val;
      end
    endcase
  end

  // Sequencer state, captured request, watchdog and completion pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      start_q  <= '0;
      end_q    <= '0;
      id_q     <= '0;
      park_val <= '0;
      rr_ptr   <= '0;
      run_cnt  <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      timeout  <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            start_q <= sel_start;
            end_q   <= sel_end;
            id_q    <= gnt_idx;
            rr_ptr  <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            state   <= LOAD;
          end
        end
        LOAD: begin
          run_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          if (match) begin
            park_val <= end_q;
            done     <= 1'b1;
            done_id  <= id_q;
            state    <= IDLE;
          end else if (run_cnt == RW'(WDOG - 1)) begin
            park_val <= '0;
            done     <= 1'b1;
            timeout  <= 1'b1;
            done_id  <= id_q;
            state    <= IDLE;
          end else begin
            run_cnt <= run_cnt + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_arbiter.sv
// Self-checking bench for counter_seq_arbiter with an attached counter model.
module tb_counter_seq_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 4;
  localparam int unsigned WDOG = 2**W + 2;
  localparam int unsigned IW   = $clog2(NREQ);

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_start;
  logic [NREQ*W-1:0]   req_end;
  logic [NREQ-1:0]     req_ready;
  logic                cnt_en;
  logic [W-1:0]        cnt_in;
  logic [W-1:0]        cnt_out;
  logic                busy;
  logic                done;
  logic [IW-1:0]       done_id;
  logic                timeout;

  logic [W-1:0]        cnt_q;
  logic                stuck;

  int unsigned total;
  int unsigned bad;
  int unsigned model_ptr;
  logic [W-1:0] run_seq[$];

  counter_seq_arbiter #(
    .NREQ(NREQ),
    .W   (W),
    .WDOG(WDOG)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_start(req_start),
    .req_end  (req_end),
    .req_ready(req_ready),
    .cnt_en   (cnt_en),
    .cnt_in   (cnt_in),
    .cnt_out  (cnt_out),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The shared counter the block controls; stuck forces a frozen output.
  always @(posedge clk) cnt_q <= cnt_en ? cnt_in : cnt_q + 4'd1;
  assign cnt_out = stuck ? 4'd9 : cnt_q;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned rr_pick(input logic [NREQ-1:0] m);
    for (int unsigned k = 0; k < NREQ; k++)
      if (m[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int unsigned id);
    logic [NREQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int unsigned id, input int unsigned s, input int unsigned e);
    req_start[id*W +: W] = W'(s);
    req_end[id*W +: W]   = W'(e);
  endtask

  // Called at the settle point of a cycle; returns in the accept cycle.
  task automatic wait_accept(output bit ok, output logic [NREQ-1:0] rdy);
    ok  = 1'b0;
    rdy = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (req_ready != '0) begin
        ok  = 1'b1;
        rdy = req_ready;
      end else begin
        cyc();
      end
    end
  endtask

  // From the accept cycle, count cycles until done; records RUN-cycle cnt_out.
  task automatic wait_done(output bit ok, output int unsigned lat,
                           output logic [IW-1:0] did, output logic to);
    ok  = 1'b0;
    lat = 0;
    did = '0;
    to  = 1'b0;
    run_seq.delete();
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc();
      lat++;
      if (lat == 1) req_valid = '0;
      if (done) begin
        ok  = 1'b1;
        did = done_id;
        to  = timeout;
      end else if (lat >= 2) begin
        run_seq.push_back(cnt_out);
      end
    end
  endtask

  // One complete request from a single requester, checked against arithmetic.
  task automatic run_single(input string name, input int unsigned id,
                            input int unsigned s, input int unsigned e);
    bit ok;
    logic [NREQ-1:0] rdy;
    int unsigned lat, d, exp_id;
    logic [IW-1:0] did;
    logic to;
    bit seq_ok;
    set_req(id, s, e);
    req_valid = onehot(id);
    exp_id = rr_pick(req_valid);
    wait_accept(ok, rdy);
    total++;
    if (!ok || rdy !== onehot(exp_id)) begin
      bad++;
      $display("FAIL %s_accept got=%b exp=%b ok=%0d", name, rdy, onehot(exp_id), ok);
    end
    model_ptr = (exp_id + 1) % NREQ;
    wait_done(ok, lat, did, to);
    d = (e - s) % (2**W);
    total++;
    if (!ok || lat != d + 3) begin
      bad++;
      $display("FAIL %s_latency got=%0d exp=%0d ok=%0d", name, lat, d + 3, ok);
    end
    total++;
    if (did !== IW'(exp_id) || to !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_id got=%0d/%0b exp=%0d/0", name, did, to, exp_id);
    end
    seq_ok = (run_seq.size() == d + 1);
    for (int unsigned i = 0; seq_ok && i <= d; i++)
      if (run_seq[i] !== W'((s + i) % (2**W))) seq_ok = 1'b0;
    total++;
    if (!seq_ok) begin
      bad++;
      $display("FAIL %s_sequence got_len=%0d exp_len=%0d", name, run_seq.size(), d + 1);
    end
    total++;
    if (cnt_out !== W'(e) || cnt_in !== W'(e) || cnt_en !== 1'b1) begin
      bad++;
      $display("FAIL %s_park got=%0d/%0d exp=%0d", name, cnt_out, cnt_in, e);
    end
  endtask

  task automatic test_reset();
    int unsigned errs;
    reset = 1'b0;
    req_valid = '1;
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (cnt_en !== 1'b1 || cnt_in !== '0 || busy !== 1'b0 || done !== 1'b0 ||
          req_ready !== '0 || timeout !== 1'b0 || done_id !== '0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL reset_state got=%0d bad_cycles exp=0", errs);
    end
    req_valid = '0;
    cyc();
    reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (cnt_en !== 1'b1 || cnt_in !== '0 || busy !== 1'b0 || done !== 1'b0 ||
          cnt_out !== '0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL idle_after_reset got=%0d bad_cycles exp=0", errs);
    end
    model_ptr = 0;
  endtask

  task automatic test_single();
    int unsigned errs;
    run_single("single", 0, 3, 7);
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (cnt_out !== 4'd7 || busy !== 1'b0 || done !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL single_hold got=%0d bad_cycles exp=0", errs);
    end
  endtask

  task automatic test_wrap_equal();
    run_single("wrap", 1, 14, 1);
    cyc();
    run_single("equal", 1, 5, 5);
    cyc();
  endtask

  task automatic test_round_robin();
    int unsigned grants, exp_id, prev_id, last_acc, lat;
    bit ok;
    set_req(0, 0, 2);
    set_req(1, 0, 2);
    req_valid = '1;
    grants = 0;
    prev_id = 0;
    last_acc = 0;
    for (int unsigned c = 0; c < 80 && grants < 4; c++) begin
      #1;
      if (req_ready != '0) begin
        exp_id = rr_pick(req_valid);
        total++;
        if (req_ready !== onehot(exp_id)) begin
          bad++;
          $display("FAIL rr_grant got=%b exp=%b", req_ready, onehot(exp_id));
        end
        if (grants > 0) begin
          total++;
          if (done !== 1'b1 || done_id !== IW'(prev_id) || c - last_acc != 5) begin
            bad++;
            $display("FAIL rr_back_to_back got=%0b/%0d/%0d exp=1/%0d/5",
                     done, done_id, c - last_acc, prev_id);
          end
        end
        model_ptr = (exp_id + 1) % NREQ;
        prev_id = exp_id;
        last_acc = c;
        grants++;
      end
      cyc();
    end
    req_valid = '0;
    total++;
    if (grants != 4) begin
      bad++;
      $display("FAIL rr_grant_count got=%0d exp=4", grants);
    end
    ok = 1'b0;
    lat = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (done) ok = 1'b1;
      else begin
        cyc();
        lat++;
      end
    end
    total++;
    if (!ok || lat != 5 || done_id !== IW'(prev_id)) begin
      bad++;
      $display("FAIL rr_last_done got=%0d/%0d exp=5/%0d", lat, done_id, prev_id);
    end
    cyc();
  endtask

  task automatic test_watchdog();
    bit ok;
    logic [NREQ-1:0] rdy;
    int unsigned lat, exp_id;
    logic [IW-1:0] did;
    logic to;
    stuck = 1'b1;
    set_req(0, 0, 5);
    req_valid = onehot(0);
    exp_id = rr_pick(req_valid);
    wait_accept(ok, rdy);
    model_ptr = (exp_id + 1) % NREQ;
    wait_done(ok, lat, did, to);
    total++;
    if (!ok || lat != WDOG + 2 || to !== 1'b1 || did !== IW'(exp_id)) begin
      bad++;
      $display("FAIL watchdog got=%0d/%0b/%0d exp=%0d/1/%0d", lat, to, did, WDOG + 2, exp_id);
    end
    total++;
    if (cnt_in !== '0 || cnt_en !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL watchdog_park got=%0d/%0b exp=0/1", cnt_in, cnt_en);
    end
    stuck = 1'b0;
    cyc();
    total++;
    if (timeout !== 1'b0 || done !== 1'b0 || cnt_out !== '0) begin
      bad++;
      $display("FAIL watchdog_after got=%0b/%0b/%0d exp=0/0/0", timeout, done, cnt_out);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok, hit, seen;
    logic [NREQ-1:0] rdy;
    int unsigned exp_id;
    set_req(0, 0, 12);
    set_req(1, 0, 12);
    exp_id = model_ptr;
    req_valid = onehot(exp_id);
    wait_accept(ok, rdy);
    cyc();
    req_valid = '0;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (cnt_out == 4'd4 && busy) hit = 1'b1;
      else cyc();
    end
    reset = 1'b0;
    #1;
    total++;
    if (!hit || busy !== 1'b0 || cnt_en !== 1'b1 || cnt_in !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run got=%0b/%0b/%0b/%0d exp=1/0/1/0", hit, busy, cnt_en, cnt_in);
    end
    cyc();
    cyc();
    reset = 1'b1;
    model_ptr = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done || busy || cnt_out != '0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_mid_quiet got=1 exp=0");
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [NREQ-1:0] rdy, m;
    int unsigned lat, exp_id, s, e, errs;
    logic [IW-1:0] did;
    logic to;
    errs = 0;
    for (int n = 0; n < 20; n++) begin
      m = NREQ'($urandom_range(1, 2**NREQ - 1));
      for (int unsigned i = 0; i < NREQ; i++)
        set_req(i, $urandom_range(0, 15), $urandom_range(0, 15));
      req_valid = m;
      exp_id = rr_pick(m);
      s = req_start[exp_id*W +: W];
      e = req_end[exp_id*W +: W];
      wait_accept(ok, rdy);
      if (!ok || rdy !== onehot(exp_id)) errs++;
      model_ptr = (exp_id + 1) % NREQ;
      wait_done(ok, lat, did, to);
      if (!ok || lat != ((e - s) % 16) + 3 || did !== IW'(exp_id) || to !== 1'b0 ||
          cnt_out !== W'(e)) begin
        errs++;
        $display("FAIL random_run%0d got=%0d/%0d exp=%0d/%0d", n, lat, did,
                 ((e - s) % 16) + 3, exp_id);
      end
      if ($urandom_range(0, 1) == 1) cyc();
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL random got=%0d bad_runs exp=0", errs);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_ptr = 0;
    stuck = 1'b0;
    cnt_q = '0;
    reset = 1'b0;
    req_valid = '0;
    req_start = '0;
    req_end = '0;
    test_reset();
    test_single();
    test_wrap_equal();
    test_round_robin();
    test_watchdog();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
